calc_bcd_conv: RTL

Sequential binary-to-BCD result stage that sits directly downstream of the 4-bit calculator datapath (adder, subtractor, multiplier). It accepts one operation result per transaction over a valid/ready handshake and selects the value according to `op`. It then converts the magnitude to three BCD digits using an 8-step shift-and-add-3 (double-dabble) sequence. Digits, a sign flag and an error flag are held for the display/output stage until it is consumed.

---
 rtl/calc_bcd_conv_if.sv | 34 +++
 rtl/calc_bcd_conv.sv | 126 ++++++++++++
 2 files changed

// File: rtl/calc_bcd_conv_if.sv
// calc_bcd_conv_if
// Groups the upstream result handshake and the downstream digit handshake
// of the binary-to-BCD result stage into one bundle.
//   upstream:   in_valid, in_ready, op, sum, carry, diff, bout, prod
//   downstream: out_valid, out_ready, bcd_h, bcd_t, bcd_o, neg, err
// modport master: the side that supplies results and consumes digits
// modport slave:  the conversion stage itself
interface calc_bcd_conv_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [3:0] sum;
    logic       carry;
    logic [3:0] diff;
    logic       bout;
    logic [7:0] prod;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] bcd_h;
    logic [3:0] bcd_t;
    logic [3:0] bcd_o;
    logic       neg;
    logic       err;

    modport master (
        output in_valid, op, sum, carry, diff, bout, prod, out_ready,
        input  in_ready, out_valid, bcd_h, bcd_t, bcd_o, neg, err
    );

    modport slave (
        input  in_valid, op, sum, carry, diff, bout, prod, out_ready,
        output in_ready, out_valid, bcd_h, bcd_t, bcd_o, neg, err
    );
endinterface

// File: rtl/calc_bcd_conv.sv
// calc_bcd_conv
// Result stage behind the 4-bit calculator datapath. Accepts one result per
// transaction, picks the magnitude selected by op, converts it to three BCD
// digits with an 8-step double-dabble and holds digits plus sign/error flags
// until the downstream stage takes them.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    calc_bcd_conv_if.slave (handshakes, operands, digits, flags)
module calc_bcd_conv (
    input logic            clk,
    input logic            rst_n,
    calc_bcd_conv_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [19:0] scratch;
    logic [19:0] scratch_next;
    logic        neg_hold;
    logic        err_hold;

    logic [7:0]  mag;
    logic        mag_neg;
    logic        mag_err;
    logic [4:0]  borrow_mag;

    // Accept only in IDLE; decoded from state so in_valid never reaches in_ready.
    assign bus.in_ready = (state == IDLE);

    // Magnitude select. A borrowed subtraction leaves diff as the two's
    // complement of the true result in 4 bits, so 16-diff recovers |a-b|;
    // 5 bits are needed because diff=0 with borrow means 16.
    always_comb begin
        borrow_mag = 5'd16 - {1'b0, bus.diff};
        mag        = 8'd0;
        mag_neg    = 1'b0;
        mag_err    = 1'b0;
        case (bus.op)
            2'b00: mag = {3'b000, bus.carry, bus.sum};
            2'b01: begin
                if (bus.bout) begin
                    mag     = {3'b000, borrow_mag};
                    mag_neg = 1'b1;
                end else begin
                    mag = {4'b0000, bus.diff};
                end
            end
            2'b10: mag = bus.prod;
            default: begin
                mag     = 8'd0;
                mag_err = 1'b1;
            end
        endcase
    end

    // One double-dabble step: add 3 to every BCD nibble that is 5 or more so
    // the following doubling carries correctly into the next decade, then
    // shift the whole {h,t,o,bin} scratch left by one.
    always_comb begin
        logic [19:0] adj;
        adj = scratch;
        if (adj[19:16] >= 4'd5) adj[19:16] = adj[19:16] + 4'd3;
        if (adj[15:12] >= 4'd5) adj[15:12] = adj[15:12] + 4'd3;
        if (adj[11:8]  >= 4'd5) adj[11:8]  = adj[11:8]  + 4'd3;
        scratch_next = {adj[18:0], 1'b0};
    end

    // Control and datapath registers. Output digits and flags load only on
    // the last shift, so they keep the previous result through IDLE/SHIFT.
    // An invalid opcode still runs all eight steps to keep latency fixed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= 3'd0;
            scratch       <= 20'd0;
            neg_hold      <= 1'b0;
            err_hold      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.bcd_h     <= 4'd0;
            bus.bcd_t     <= 4'd0;
            bus.bcd_o     <= 4'd0;
            bus.neg       <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        scratch  <= {12'd0, mag};
                        neg_hold <= mag_neg;
                        err_hold <= mag_err;
                        cnt      <= 3'd0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_next;
                    cnt     <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        bus.bcd_h     <= scratch_next[19:16];
                        bus.bcd_t     <= scratch_next[15:12];
                        bus.bcd_o     <= scratch_next[11:8];
                        bus.neg       <= neg_hold;
                        bus.err       <= err_hold;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
